// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the unified-memory port arbiter
// Purpose: owner encoding of the outstanding access, data word width, and the
//          misaligned-address check used on the load/store side.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int ARB_WORD = 32;

    // A data access is only legal on a word boundary.
    function automatic logic is_misaligned(input logic [ARB_WORD-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner select between fetch and load/store
// Purpose: grants at most one eligible requester per cycle.
// Ports:   i_elig/d_elig - requester may issue this cycle
//          i_first       - fetch side wins a contended cycle (priority/starve state)
//          grant_i/grant_d - one-hot (or zero) grant
module arb_pick (
    input  logic i_elig,
    input  logic d_elig,
    input  logic i_first,
    output logic grant_i,
    output logic grant_d
);

    assign grant_i = i_elig & (~d_elig | i_first);
    assign grant_d = d_elig & (~i_elig | ~i_first);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous single-port memory between fetch and load/store
// Purpose: issues one access per cycle, returns data one cycle later with an ack
//          pulse, and rejects misaligned load/store accesses without touching memory.
// Config:  ARB_ROUND_ROBIN_EN defined   -> contended cycles alternate winners
//          ARB_ROUND_ROBIN_EN undefined -> load/store wins, fetch forced after STARVE_MAX losses
// Ports:   clk, reset (async, active-high)
//          i_req/i_addr -> i_ack/i_rdata                  fetch side (read-only)
//          d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata/d_err  load/store side
//          mem_en/mem_we/mem_addr/mem_wdata, mem_rdata    memory macro side
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ARB_WORD-1:0] i_addr,
    output logic                i_ack,
    output logic [ARB_WORD-1:0] i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ARB_WORD-1:0] d_addr,
    input  logic [ARB_WORD-1:0] d_wdata,
    output logic                d_ack,
    output logic [ARB_WORD-1:0] d_rdata,
    output logic                d_err,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [ARB_WORD-1:0] mem_wdata,
    input  logic [ARB_WORD-1:0] mem_rdata
);

    owner_t              owner_q, owner_d;
    logic                d_write_q, d_write_d;
    logic                d_err_q, d_err_d;
    logic [ARB_WORD-1:0] i_rdata_q, i_rdata_d;
    logic [ARB_WORD-1:0] d_rdata_q, d_rdata_d;
    logic [ARB_WORD-1:0] d_resp_data;
    logic                i_elig, d_elig, i_first;
    logic                grant_i, grant_d;
    logic                d_mis, d_mem;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[ARB_WORD-1:AW+2], i_addr[1:0], d_addr[ARB_WORD-1:AW+2]};

    assign i_ack = (owner_q == OWN_I);
    assign d_ack = (owner_q == OWN_D);
    assign d_err = d_err_q;

    // A requester being acked still shows req from the finished access, so it
    // sits out this cycle; the other side can use the slot.
    assign i_elig = i_req & ~i_ack & ~reset;
    assign d_elig = d_req & ~d_ack & ~reset;
    assign d_mis  = is_misaligned(d_addr);
    // A misaligned grant burns the slot but never reaches the memory.
    assign d_mem  = grant_d & ~d_mis;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_winner_q, last_winner_d;
    assign i_first = (last_winner_q == OWN_D);
`else
    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    assign i_first = (starve_cnt_q == STARVE_LIM);
`endif

    arb_pick u_pick (
        .i_elig  (i_elig),
        .d_elig  (d_elig),
        .i_first (i_first),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_comb begin
        owner_d = OWN_NONE;
        if (grant_i) begin
            owner_d = OWN_I;
        end else if (grant_d) begin
            owner_d = OWN_D;
        end
        d_write_d = grant_d & d_we;
        d_err_d   = grant_d & d_mis;

        mem_en    = (grant_i | d_mem) & ~reset;
        mem_we    = d_mem & d_we & ~reset;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_i) begin
            mem_addr = i_addr[AW+1:2];
        end else if (d_mem) begin
            mem_addr = d_addr[AW+1:2];
            if (d_we) begin
                mem_wdata = d_wdata;
            end
        end

        // Stores and rejected accesses return zero; read data is live from the
        // memory during the ack cycle and held afterwards.
        d_resp_data = (d_write_q | d_err_q) ? '0 : mem_rdata;
        i_rdata_d   = i_ack ? mem_rdata : i_rdata_q;
        d_rdata_d   = d_ack ? d_resp_data : d_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
        last_winner_d = last_winner_q;
        if (i_elig & d_elig) begin
            last_winner_d = grant_i ? OWN_I : OWN_D;
        end
`else
        starve_cnt_d = starve_cnt_q;
        if (grant_i) begin
            starve_cnt_d = '0;
        end else if (i_elig && starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
`endif
    end

    assign i_rdata = i_rdata_d;
    assign d_rdata = d_rdata_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q       <= OWN_NONE;
            d_write_q     <= 1'b0;
            d_err_q       <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_winner_q <= OWN_I;
`else
            starve_cnt_q  <= '0;
`endif
        end else begin
            owner_q       <= owner_d;
            d_write_q     <= d_write_d;
            d_err_q       <= d_err_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_winner_q <= last_winner_d;
`else
            starve_cnt_q  <= starve_cnt_d;
`endif
        end
    end

endmodule
